is_uart_rx_fsm: RTL and testbench
=================================

Name: is_uart_rx_fsm

Overview:
UART receiver, the counterpart of the team's UART transmitter FSM. Frame format: start bit, DATA_W data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Samples rxd_i with a 16x oversampling clock-enable supplied by the shared baud generator.
- Returns each received word with per-frame parity and framing error flags.
- Sits between the pad-side RXD line and the UART controller register/FIFO logic.

Parameters:
PAR_EN, 1, 1 = parity bit present in frame; 0 = no parity bit.
PAR_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PAR_EN = 0.
STOP_BITS, 2, number of stop bits, legal values 1 or 2; both are checked.

Ports:
clk_i  input  1  system clock
rstn_i  input  1  reset
rx_ce16_i  input  1  one-clk strobe at 16x baud rate
rxd_i  input  1  asynchronous serial line, idle high
rx_data_r_o  output  DATA_W  last received word, held until next frame completes
rx_vld_r_o  output  1  one-clk pulse, rx_data_r_o/error flags valid
rx_par_err_r_o  output  1  parity mismatch for the frame tagged by rx_vld_r_o
rx_frm_err_r_o  output  1  a stop bit sampled low in the frame tagged by rx_vld_r_o
rxct_r_o  output  1  0 while a frame is being received, 1 when idle

Behaviour:
- Reset: rstn_i, asynchronous, active-low; clock clk_i.
- Reset values: rx_data_r_o = 0, rx_vld_r_o = 0, both error flags = 0, rxct_r_o = 1, state = IDLE.
- Internal counters and the synchronizer are cleared on reset; synchronizer flops reset to 1.
- Input conditioning: rxd_i passes through a 2-flop synchronizer; all logic uses the synchronized value rxd_s.
- Tick counter: 4 bits, advances only on rx_ce16_i.
- Bit decision: majority of the 3 samples taken at ticks 7, 8 and 9 of each bit period.
- States and transitions:
  - IDLE: on rx_ce16_i with rxd_s = 0 -> START; clear the tick counter, set rxct_r_o = 0.
  - START: at tick 9, voted value 1 -> IDLE, no output (glitch rejection), rxct_r_o = 1. Voted value 0 -> DATA at tick 15 wrap.
  - DATA: at each tick 9, shift the voted bit into the MSB of the shift register (right shift, LSB arrives first). Bit counter 0..DATA_W-1. After the last bit's tick 15 -> PARB if PAR_EN = 1, else STOP.
  - PARB: at tick 9, capture the voted parity bit.
    - Expected bit = XOR of the data bits, XOR PAR_ODD.
    - Mismatch sets the internal parity error.
    - At tick 15 -> STOP.
  - STOP: at tick 9 of each stop bit, a voted 0 sets the internal framing error.
    - After tick 9 of the final stop bit (bit STOP_BITS), in the same clk: load rx_data_r_o and both error flags, pulse rx_vld_r_o, set rxct_r_o = 1, go to IDLE.
    - Returning to IDLE mid-stop-bit permits back-to-back frames and baud tolerance.
- Latency: rx_vld_r_o rises on the clk edge after the rx_ce16_i that carries tick 9 of the final stop bit.
- Framing error frames are still delivered, with rx_frm_err_r_o = 1.
- Break (line held low):
  - The frame is reported with rx_frm_err_r_o = 1.
  - The FSM then stays in IDLE until rxd_s has been seen high on at least one rx_ce16_i; it does not restart on the same low level.
- Errors and data are registered only at rx_vld_r_o; they hold until the next rx_vld_r_o.
- No handshake back-pressure: the consumer must take data within one frame time. rx_vld_r_o is never held more than one cycle.
- rx_ce16_i low: state, counters and samples are frozen; outputs stay stable.
- Reset asserted mid-frame: immediate return to the reset values; the partial frame is discarded and no rx_vld_r_o is produced.
- Illegal state encodings -> IDLE.

Decomposition:
- DATA_W comes from is_pkg_uart_controller.
- Add to the package:
  - rx_state_t enum: IDLE, START, DATA, PARB, STOP.
  - OVS = 16 and the sample tick constants 7/8/9/15.
- One sub-module: is_uart_rx_sampler. It holds the 2-flop synchronizer, tick counter and 3-sample majority voter, and outputs rxd_s, tick and bit_smp_vld.

Test Plan:
- Even parity, STOP_BITS = 2: send 0xA5, parity 0, stop 11 -> one rx_vld_r_o pulse, rx_data_r_o = 0xA5, both error flags 0, rxct_r_o low for the whole frame.
- Glitch: rxd_i low for 4 rx_ce16_i ticks, then high -> no rx_vld_r_o, rxct_r_o back to 1 at tick 9, next valid frame 0x3C is received correctly.
- Parity error: 0x01 with parity bit 0 (even expects 1) -> rx_data_r_o = 0x01, rx_par_err_r_o = 1; the next correct frame clears it.
- Framing/break: rxd_i held low for 3 frame times -> single rx_vld_r_o with rx_data_r_o = 0x00 and rx_frm_err_r_o = 1; no further pulse until the line has returned high.
- Back-to-back frames 0x55, 0xAA, 0xFF at ±3% baud skew -> three pulses with correct data and no errors.
- Reset mid-DATA after 4 bits of 0x0F -> all outputs at reset values, no pulse; a frame of 0xC3 after release is received correctly.

Source files
------------

// File: rtl/is_pkg_uart_controller.sv
// Shared UART controller constants used by the TX and RX datapaths.
// Latency: none, constants only.
// Backpressure: none, constants only.
package is_pkg_uart_controller;

    // Width of one UART character.
    localparam int DATA_W = 8;

endpackage

// File: rtl/is_uart_rx_fsm_pkg.sv
// UART receiver types, oversampling constants and the bit voter.
// Latency: none, constants and a combinational helper only.
// Backpressure: none, constants only.
package is_uart_rx_fsm_pkg;

    localparam int DATA_W = is_pkg_uart_controller::DATA_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PARB  = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    // Oversampling ratio and the tick positions inside one bit period.
    localparam int         OVS      = 16;
    localparam int         TICK_W   = $clog2(OVS);
    localparam logic [3:0] TICK_S0  = 4'd7;
    localparam logic [3:0] TICK_S1  = 4'd8;
    localparam logic [3:0] TICK_S2  = 4'd9;
    localparam logic [3:0] TICK_END = 4'd15;

    // 2-of-3 majority, rejects a single noisy sample near mid-bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/is_uart_rx_fsm_if.sv
// Pad-side serial input and controller-side received-word bundle.
// Latency: none, wiring only.
// Backpressure: none; the consumer must take each word within one frame time.
interface is_uart_rx_fsm_if;
    import is_uart_rx_fsm_pkg::*;

    logic              rx_ce16_i;
    logic              rxd_i;
    logic [DATA_W-1:0] rx_data_r_o;
    logic              rx_vld_r_o;
    logic              rx_par_err_r_o;
    logic              rx_frm_err_r_o;
    logic              rxct_r_o;

    // Drives the line and baud strobe, consumes received words.
    modport master (
        output rx_ce16_i, rxd_i,
        input  rx_data_r_o, rx_vld_r_o, rx_par_err_r_o, rx_frm_err_r_o, rxct_r_o
    );

    // The receiver itself.
    modport slave (
        input  rx_ce16_i, rxd_i,
        output rx_data_r_o, rx_vld_r_o, rx_par_err_r_o, rx_frm_err_r_o, rxct_r_o
    );

endinterface

// File: rtl/is_uart_rx_sampler.sv
// RXD synchronizer, 16x tick counter and 3-sample majority voter.
// Latency: 2 clk synchronizer; vote is combinational on the tick-9 strobe.
// Backpressure: none; everything advances only on rx_ce16_i.
module is_uart_rx_sampler
    import is_uart_rx_fsm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rx_ce16_i,
    input  logic              rxd_i,
    input  logic              tick_clr,
    output logic              rxd_s,
    output logic [TICK_W-1:0] tick,
    output logic              bit_smp_vld,
    output logic              bit_smp
);

    logic              rxd_m;
    logic [TICK_W-1:0] tick_cnt;
    logic              smp_a;
    logic              smp_b;

    // Two-flop synchronizer, reset high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd_i;
            rxd_s <= rxd_m;
        end
    end

    // tick is the index carried by the current strobe; the start-detect strobe is tick 0.
    assign tick = tick_cnt + TICK_W'(1);

    // Tick counter, restarted by the FSM when it sees a start edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tick_cnt <= '0;
        end else if (rx_ce16_i) begin
            tick_cnt <= tick_clr ? '0 : tick;
        end
    end

    // Hold the first two mid-bit samples; the third is taken live at tick 9.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else if (rx_ce16_i) begin
            if (tick == TICK_S0) smp_a <= rxd_s;
            if (tick == TICK_S1) smp_b <= rxd_s;
        end
    end

    assign bit_smp_vld = rx_ce16_i && (tick == TICK_S2);
    assign bit_smp     = maj3(smp_a, smp_b, rxd_s);

endmodule

// File: rtl/is_uart_rx_fsm.sv
// UART receiver: start, DATA_W bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: rx_vld_r_o on the clk after the strobe carrying tick 9 of the last stop bit.
// Backpressure: none; one-clk valid pulse, word and flags held until the next frame.
module is_uart_rx_fsm
    import is_uart_rx_fsm_pkg::*;
#(
    parameter logic PAR_EN    = 1'b1,
    parameter logic PAR_ODD   = 1'b0,
    parameter int   STOP_BITS = 2
)(
    input  logic              clk_i,
    input  logic              rstn_i,
    is_uart_rx_fsm_if.slave   rx_if
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_START = 3'(START);
    localparam logic [2:0] S_DATA  = 3'(DATA);
    localparam logic [2:0] S_PARB  = 3'(PARB);
    localparam logic [2:0] S_STOP  = 3'(STOP);

    localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2:0]           state;
    logic [DATA_W-1:0]    shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 stop_cnt;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 brk_wait;

    logic                 rxd_s;
    logic [TICK_W-1:0]    tick;
    logic                 bit_smp_vld;
    logic                 bit_smp;
    logic                 tick_clr;
    logic                 tick_end;
    logic                 last_stop;

    // A start edge is only accepted once the line has been seen high after a break.
    assign tick_clr  = rx_if.rx_ce16_i && (state == S_IDLE) && !rxd_s && !brk_wait;
    assign tick_end  = rx_if.rx_ce16_i && (tick == TICK_END);
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    is_uart_rx_sampler u_sampler (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rx_ce16_i   (rx_if.rx_ce16_i),
        .rxd_i       (rx_if.rxd_i),
        .tick_clr    (tick_clr),
        .rxd_s       (rxd_s),
        .tick        (tick),
        .bit_smp_vld (bit_smp_vld),
        .bit_smp     (bit_smp)
    );

    // Frame sequencer; the word is delivered at mid final stop bit so back-to-back frames resync.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state                <= S_IDLE;
            shreg                <= '0;
            bit_cnt              <= '0;
            stop_cnt             <= 1'b0;
            par_err_q            <= 1'b0;
            frm_err_q            <= 1'b0;
            brk_wait             <= 1'b0;
            rx_if.rx_data_r_o    <= '0;
            rx_if.rx_vld_r_o     <= 1'b0;
            rx_if.rx_par_err_r_o <= 1'b0;
            rx_if.rx_frm_err_r_o <= 1'b0;
            rx_if.rxct_r_o       <= 1'b1;
        end else begin
            rx_if.rx_vld_r_o <= 1'b0;
            if (brk_wait && rx_if.rx_ce16_i && rxd_s) begin
                brk_wait <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (tick_clr) begin
                        state          <= S_START;
                        par_err_q      <= 1'b0;
                        frm_err_q      <= 1'b0;
                        rx_if.rxct_r_o <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_smp_vld && bit_smp) begin
                        state          <= S_IDLE;
                        rx_if.rxct_r_o <= 1'b1;
                    end else if (tick_end) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_smp_vld) begin
                        shreg <= {bit_smp, shreg[DATA_W-1:1]};
                    end
                    if (tick_end) begin
                        if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                            state    <= PAR_EN ? S_PARB : S_STOP;
                            stop_cnt <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                S_PARB: begin
                    if (bit_smp_vld) begin
                        par_err_q <= bit_smp ^ (^shreg) ^ PAR_ODD;
                    end
                    if (tick_end) begin
                        state    <= S_STOP;
                        stop_cnt <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (bit_smp_vld) begin
                        if (last_stop) begin
                            state                <= S_IDLE;
                            rx_if.rx_data_r_o    <= shreg;
                            rx_if.rx_par_err_r_o <= par_err_q;
                            rx_if.rx_frm_err_r_o <= frm_err_q | ~bit_smp;
                            rx_if.rx_vld_r_o     <= 1'b1;
                            rx_if.rxct_r_o       <= 1'b1;
                            brk_wait             <= ~bit_smp;
                        end else if (!bit_smp) begin
                            frm_err_q <= 1'b1;
                        end
                    end else if (tick_end) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    rx_if.rxct_r_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_is_uart_rx_fsm.sv
// Directed bench for the UART receiver with a received-word scoreboard.
// Latency: strobe every 8 clk, nominal bit time 128 clk.
// Backpressure: none; every valid pulse is popped against the expected queue.
module tb_is_uart_rx_fsm;

    localparam logic PAR_ODD_TB = 1'b0;
    localparam int   BCLK       = 128;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       frm;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    is_uart_rx_fsm_if rx_if();

    is_uart_rx_fsm #(
        .PAR_EN    (1'b1),
        .PAR_ODD   (PAR_ODD_TB),
        .STOP_BITS (2)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .rx_if  (rx_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 16x baud strobe: one clk high out of every 8.
    initial begin
        int n;
        n = 0;
        rx_if.rx_ce16_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rx_if.rx_ce16_i = (n == 7);
            n = (n + 1) % 8;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic frm);
        exp_t e;
        e.data = d;
        e.par  = p ^ (^d) ^ PAR_ODD_TB;
        e.frm  = frm;
        exp_q.push_back(e);
    endtask

    task automatic check_pulse();
        exp_t e;
        chk("vld_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_data", 32'(rx_if.rx_data_r_o), 32'(e.data));
            chk("par_err", 32'(rx_if.rx_par_err_r_o), 32'(e.par));
            chk("frm_err", 32'(rx_if.rx_frm_err_r_o), 32'(e.frm));
            chk("rxct_at_vld", 32'(rx_if.rxct_r_o), 1);
        end
    endtask

    task automatic run_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rx_if.rx_vld_r_o === 1'b1) check_pulse();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] stp, input int bclk);
        logic [11:0] bits;
        logic        rxct_bad;
        bits     = {stp[1], stp[0], p, d, 1'b0};
        rxct_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_if.rxd_i = bits[i];
            run_clks(bclk / 2);
            if (i >= 1 && i <= 10 && rx_if.rxct_r_o !== 1'b0) rxct_bad = 1'b1;
            run_clks(bclk - bclk / 2);
        end
        chk("rxct_low_in_frame", 32'(rxct_bad), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, 32'(rx_if.rx_data_r_o), 0);
        chk({tag, "_vld"}, 32'(rx_if.rx_vld_r_o), 0);
        chk({tag, "_par"}, 32'(rx_if.rx_par_err_r_o), 0);
        chk({tag, "_frm"}, 32'(rx_if.rx_frm_err_r_o), 0);
        chk({tag, "_rxct"}, 32'(rx_if.rxct_r_o), 1);
    endtask

    initial begin
        int         skew [2];
        logic [7:0] b2b [3];
        skew = '{124, 132};
        b2b  = '{8'h55, 8'hAA, 8'hFF};

        rstn        = 1'b0;
        rx_if.rxd_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rstn = 1'b1;
        run_clks(100);

        // Clean frame, even parity, two stop bits.
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 2'b11, BCLK);
        run_clks(200);
        chk("q_empty_a5", 32'(exp_q.size()), 0);
        chk("data_hold_a5", 32'(rx_if.rx_data_r_o), 32'hA5);

        // Short low glitch must be rejected at the start-bit vote.
        rx_if.rxd_i = 1'b0;
        run_clks(24);
        chk("rxct_glitch_busy", 32'(rx_if.rxct_r_o), 0);
        run_clks(8);
        rx_if.rxd_i = 1'b1;
        run_clks(100);
        chk("rxct_glitch_idle", 32'(rx_if.rxct_r_o), 1);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 2'b11, BCLK);
        run_clks(200);
        chk("q_empty_3c", 32'(exp_q.size()), 0);

        // Parity error, then a good frame clears the flag.
        push_exp(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 2'b11, BCLK);
        push_exp(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 2'b11, BCLK);
        run_clks(200);
        chk("q_empty_par", 32'(exp_q.size()), 0);
        chk("par_err_cleared", 32'(rx_if.rx_par_err_r_o), 0);

        // Break: line low for three frame times gives exactly one framing-error word.
        push_exp(8'h00, 1'b0, 1'b1);
        rx_if.rxd_i = 1'b0;
        run_clks(3 * 12 * BCLK);
        chk("brk_single_pulse", 32'(exp_q.size()), 0);
        chk("brk_idle_rxct", 32'(rx_if.rxct_r_o), 1);
        chk("brk_frm_held", 32'(rx_if.rx_frm_err_r_o), 1);
        rx_if.rxd_i = 1'b1;
        run_clks(2 * BCLK);

        // Back-to-back frames with fast and slow transmitter baud.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 3; k++) begin
                push_exp(b2b[k], ^b2b[k] ^ PAR_ODD_TB, 1'b0);
                send_frame(b2b[k], ^b2b[k] ^ PAR_ODD_TB, 2'b11, skew[s]);
            end
            run_clks(300);
            chk("q_empty_b2b", 32'(exp_q.size()), 0);
        end

        // Reset in the middle of data bits of 0x0F discards the partial frame.
        rx_if.rxd_i = 1'b0;
        run_clks(BCLK);
        rx_if.rxd_i = 1'b1;
        run_clks(4 * BCLK);
        rx_if.rxd_i = 1'b0;
        run_clks(BCLK / 2);
        rstn = 1'b0;
        run_clks(2);
        chk_reset_vals("midreset");
        rx_if.rxd_i = 1'b1;
        run_clks(20);
        rstn = 1'b1;
        run_clks(4 * BCLK);
        chk("midreset_no_pulse_data", 32'(rx_if.rx_data_r_o), 0);
        push_exp(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 2'b11, BCLK);
        run_clks(300);
        chk("q_empty_c3", 32'(exp_q.size()), 0);
        chk("data_final_c3", 32'(rx_if.rx_data_r_o), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
